// File: rtl/vga_sync.sv
// VGA raster timing generator: pixel-rate tick, h/v position counters and
// registered sync / video-enable outputs that all describe the same position.
module vga_sync #(
  parameter int TICK_DIV  = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(TICK_DIV);

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [9:0]       H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0]       V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0]       HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]       HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]       VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]       VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_next_s;
  logic             tick_s;
  logic [9:0]       h_next_s;
  logic [9:0]       v_next_s;
  logic             frame_wrap_s;

  // Next divider phase and next raster position; counters move only at the end of a tick cycle.
  always_comb begin
    div_next_s   = div_r;
    h_next_s     = pixel_x;
    v_next_s     = pixel_y;
    tick_s       = (div_r == DIV_MAX);
    frame_wrap_s = 1'b0;
    if (tick_s) begin
      div_next_s = '0;
      if (pixel_x == H_MAX) begin
        h_next_s = 10'd0;
        if (pixel_y == V_MAX) begin
          v_next_s     = 10'd0;
          frame_wrap_s = 1'b1;
        end else begin
          v_next_s = pixel_y + 10'd1;
        end
      end else begin
        h_next_s = pixel_x + 10'd1;
      end
    end else begin
      div_next_s = div_r + DIV_ONE;
    end
  end

  // State and output registers; decoding the next position keeps sync aligned with pixel_x/pixel_y.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r       <= '0;
      pixel_x     <= 10'd0;
      pixel_y     <= 10'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b1;
      p_tick      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_r       <= div_next_s;
      pixel_x     <= h_next_s;
      pixel_y     <= v_next_s;
      hsync       <= !((h_next_s >= HS_START) && (h_next_s <= HS_END));
      vsync       <= !((v_next_s >= VS_START) && (v_next_s <= VS_END));
      video_on    <= (h_next_s < H_VIS) && (v_next_s < V_VIS);
      p_tick      <= (div_next_s == DIV_MAX);
      frame_start <= frame_wrap_s;
    end
  end

endmodule

// File: tb/tb_vga_sync.sv
// Self-checking bench for vga_sync: a full-size and a reduced-size instance are
// compared every cycle against an arithmetic model driven by elapsed clock count.
module tb_vga_sync;

  typedef struct {
    int td; int hd; int hf; int hs; int hb; int vd; int vf; int vs; int vb;
  } timing_t;

  localparam timing_t BIG = '{td:4, hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33};
  localparam timing_t SML = '{td:2, hd:8, hf:2, hs:2, hb:2, vd:4, vf:1, vs:1, vb:1};

  logic       clk = 1'b0;
  logic       rst_big_s;
  logic       rst_sml_s;
  logic       big_hs_s, big_vs_s, big_vid_s, big_tick_s, big_fs_s;
  logic [9:0] big_x_s, big_y_s;
  logic       sml_hs_s, sml_vs_s, sml_vid_s, sml_tick_s, sml_fs_s;
  logic [9:0] sml_x_s, sml_y_s;

  longint k_big_r = 0;
  longint k_sml_r = 0;
  bit     armed_big_r = 1'b0;
  bit     armed_sml_r = 1'b0;
  int     n_checks = 0;
  int     n_errors = 0;

  always #5 clk = ~clk;

  vga_sync u_big (
    .clk(clk), .reset(rst_big_s), .hsync(big_hs_s), .vsync(big_vs_s),
    .video_on(big_vid_s), .p_tick(big_tick_s), .pixel_x(big_x_s),
    .pixel_y(big_y_s), .frame_start(big_fs_s)
  );

  vga_sync #(
    .TICK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_sml (
    .clk(clk), .reset(rst_sml_s), .hsync(sml_hs_s), .vsync(sml_vs_s),
    .video_on(sml_vid_s), .p_tick(sml_tick_s), .pixel_x(sml_x_s),
    .pixel_y(sml_y_s), .frame_start(sml_fs_s)
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected outputs after k clock edges out of reset, from plain division of elapsed time.
  task automatic verify(input string pfx, input longint k, input timing_t t,
                        input int ax, input int ay, input bit ahs, input bit avs,
                        input bit avid, input bit atick, input bit afs);
    longint p, pf;
    int ht, vt, ex, ey;
    ht = t.hd + t.hf + t.hs + t.hb;
    vt = t.vd + t.vf + t.vs + t.vb;
    p  = k / t.td;
    pf = p % (ht * vt);
    ex = int'(pf % ht);
    ey = int'(pf / ht);
    check_eq($sformatf("%s.x@%0d", pfx, k), ax, ex);
    check_eq($sformatf("%s.y@%0d", pfx, k), ay, ey);
    check_eq($sformatf("%s.hsync@%0d", pfx, k), ahs,
             (ex >= t.hd + t.hf && ex < t.hd + t.hf + t.hs) ? 0 : 1);
    check_eq($sformatf("%s.vsync@%0d", pfx, k), avs,
             (ey >= t.vd + t.vf && ey < t.vd + t.vf + t.vs) ? 0 : 1);
    check_eq($sformatf("%s.video_on@%0d", pfx, k), avid, (ex < t.hd && ey < t.vd) ? 1 : 0);
    check_eq($sformatf("%s.p_tick@%0d", pfx, k), atick, (k % t.td == t.td - 1) ? 1 : 0);
    check_eq($sformatf("%s.frame_start@%0d", pfx, k), afs,
             (k % t.td == 0 && p > 0 && pf == 0) ? 1 : 0);
  endtask

  // Elapsed-edge counters seen by the model; cleared by each instance's reset.
  always @(posedge clk) begin
    if (rst_big_s) begin k_big_r <= 0; armed_big_r <= 1'b1; end
    else k_big_r <= k_big_r + 1;
    if (rst_sml_s) begin k_sml_r <= 0; armed_sml_r <= 1'b1; end
    else k_sml_r <= k_sml_r + 1;
  end

  // Continuous comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (armed_big_r)
      verify("big", k_big_r, BIG, int'(big_x_s), int'(big_y_s), big_hs_s, big_vs_s,
             big_vid_s, big_tick_s, big_fs_s);
    if (armed_sml_r)
      verify("sml", k_sml_r, SML, int'(sml_x_s), int'(sml_y_s), sml_hs_s, sml_vs_s,
             sml_vid_s, sml_tick_s, sml_fs_s);
  end

  task automatic wait_xy(input bit sel, input int tx, input int ty, input int budget);
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    while (n < budget && !found) begin
      if (sel ? (int'(sml_x_s) == tx && int'(sml_y_s) == ty)
              : (int'(big_x_s) == tx && int'(big_y_s) == ty)) found = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check_eq($sformatf("wait_xy(%0d,%0d)", tx, ty), found, 1);
  endtask

  initial begin
    int ticks, bad, lo, minx, maxx, vlo, miny, maxy;
    longint fs_q[$];
    rst_big_s = 1'b1;
    rst_sml_s = 1'b1;
    repeat (3) @(negedge clk);

    // Tick cadence on the full-size instance.
    rst_big_s = 1'b0;
    ticks = 0;
    bad = 0;
    for (int j = 0; j < 40; j++) begin
      if (big_tick_s !== ((j % 4) == 3)) bad++;
      if (big_tick_s) ticks++;
      @(negedge clk);
    end
    check_eq("tick_pattern", bad, 0);
    check_eq("tick_count", ticks, 10);
    check_eq("x_after_40", big_x_s, 10);

    // Horizontal visible window and hsync pulse.
    wait_xy(1'b0, 639, 0, 4 * 700);
    check_eq("video_on_639", big_vid_s, 1);
    repeat (4) @(negedge clk);
    check_eq("x_640", big_x_s, 640);
    check_eq("video_on_640", big_vid_s, 0);
    lo = 0; minx = 1023; maxx = 0;
    for (int n = 0; n < 800 && big_x_s != 10'd799; n++) begin
      if (!big_hs_s) begin
        lo++;
        if (int'(big_x_s) < minx) minx = int'(big_x_s);
        if (int'(big_x_s) > maxx) maxx = int'(big_x_s);
      end
      @(negedge clk);
    end
    check_eq("hsync_low_clks", lo, 384);
    check_eq("hsync_first_x", minx, 656);
    check_eq("hsync_last_x", maxx, 751);

    // Line wrap.
    check_eq("x_799", big_x_s, 799);
    check_eq("y_line0", big_y_s, 0);
    repeat (4) @(negedge clk);
    check_eq("wrap_x", big_x_s, 0);
    check_eq("wrap_y", big_y_s, 1);
    check_eq("wrap_hsync", big_hs_s, 1);
    check_eq("wrap_frame_start", big_fs_s, 0);

    // Full frames on the reduced instance: 14-pixel lines, 7 lines, 196 clks per frame.
    rst_sml_s = 1'b0;
    vlo = 0; miny = 1023; maxy = 0;
    for (int j = 0; j <= 400; j++) begin
      if (sml_fs_s) begin
        fs_q.push_back(longint'(j));
        check_eq("fs_at_origin", {sml_x_s, sml_y_s}, 0);
      end
      if (j < 196 && !sml_vs_s) begin
        vlo++;
        if (int'(sml_y_s) < miny) miny = int'(sml_y_s);
        if (int'(sml_y_s) > maxy) maxy = int'(sml_y_s);
      end
      @(negedge clk);
    end
    check_eq("fs_pulses", fs_q.size(), 2);
    if (fs_q.size() >= 2) begin
      check_eq("fs_first", fs_q[0], 196);
      check_eq("fs_period", fs_q[1] - fs_q[0], 196);
    end
    check_eq("vsync_low_clks", vlo, 28);
    check_eq("vsync_first_y", miny, 5);
    check_eq("vsync_last_y", maxy, 5);

    // Reset in the middle of the vsync line.
    wait_xy(1'b1, 12, 5, 400);
    check_eq("pre_reset_vsync", sml_vs_s, 0);
    rst_sml_s = 1'b1;
    @(negedge clk);
    check_eq("rst_x", sml_x_s, 0);
    check_eq("rst_y", sml_y_s, 0);
    check_eq("rst_hsync", sml_hs_s, 1);
    check_eq("rst_vsync", sml_vs_s, 1);
    check_eq("rst_video_on", sml_vid_s, 1);
    check_eq("rst_p_tick", sml_tick_s, 0);
    check_eq("rst_frame_start", sml_fs_s, 0);
    repeat (4) @(negedge clk);
    rst_sml_s = 1'b0;

    // Random reset pulses at arbitrary phase; the continuous model checks every cycle.
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(1, 300)) @(negedge clk);
      rst_sml_s = 1'b1;
      if ($urandom_range(0, 3) == 0) rst_big_s = 1'b1;
      repeat ($urandom_range(1, 5)) @(negedge clk);
      rst_sml_s = 1'b0;
      rst_big_s = 1'b0;
    end
    repeat (50) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
